// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_wr_arbiter                                         |
// | Description : Two-source (ALU / MEM) writeback arbiter for the single    |
// |               register-file write port. 1-entry holding register per     |
// |               source, oldest-first arbitration with round-robin on ties, |
// |               registered write outputs and a pending-write mask.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module regfile_wr_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 5,
   parameter int ZERO_REG_RO = 1,
   parameter int TIE_FIRST   = 0
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         alu_valid_i,
   output logic                         alu_ready_o,
   input  logic [ADDR_WIDTH-1:0]        alu_addr_i,
   input  logic [DATA_WIDTH-1:0]        alu_data_i,
   input  logic                         mem_valid_i,
   output logic                         mem_ready_o,
   input  logic [ADDR_WIDTH-1:0]        mem_addr_i,
   input  logic [DATA_WIDTH-1:0]        mem_data_i,
   output logic                         wr_en_o,
   output logic [ADDR_WIDTH-1:0]        wr_addr_o,
   output logic [DATA_WIDTH-1:0]        wr_data_o,
   output logic                         wr_src_o,
   output logic [(2**ADDR_WIDTH)-1:0]   pend_mask_o
);

   localparam int  NREGS   = 2**ADDR_WIDTH;
   localparam logic RR_RST = (TIE_FIRST != 0);
   localparam logic ZRO    = (ZERO_REG_RO != 0);

   // Holding registers, index 0 = ALU, index 1 = MEM
   logic [1:0]            hold_v_q,    hold_v_d;
   logic [ADDR_WIDTH-1:0] hold_addr_q [2];
   logic [DATA_WIDTH-1:0] hold_data_q [2];
   // age_q: 1 = MEM entry is older; tie_q: both entries captured on the same edge
   logic                  age_q, age_d;
   logic                  tie_q, tie_d;
   logic                  rr_ptr_q, rr_ptr_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  wr_src_q, wr_src_d;

   logic [1:0]            w_valid;
   logic [ADDR_WIDTH-1:0] w_in_addr [2];
   logic [DATA_WIDTH-1:0] w_in_data [2];
   logic                  w_any;
   logic                  w_sel;
   logic [1:0]            w_grant;
   logic [1:0]            w_ready;
   logic [1:0]            w_xfer;
   logic [NREGS-1:0]      w_pend;

   // Arbiter: single holder wins, otherwise older entry, round-robin on a same-edge tie
   always_comb begin
      w_valid      = {mem_valid_i, alu_valid_i};
      w_in_addr[0] = alu_addr_i;
      w_in_addr[1] = mem_addr_i;
      w_in_data[0] = alu_data_i;
      w_in_data[1] = mem_data_i;
      w_any        = |hold_v_q;
      if (&hold_v_q) begin
         w_sel = tie_q ? rr_ptr_q : age_q;
      end else begin
         w_sel = hold_v_q[1];
      end
      w_grant = w_any ? (2'b01 << w_sel) : 2'b00;
      w_ready = ~hold_v_q | w_grant;
      // Offers made while flushing are dropped
      w_xfer  = w_valid & w_ready & {2{~flush_i}};
   end

   assign alu_ready_o = w_ready[0];
   assign mem_ready_o = w_ready[1];

   // Next-state for holding flags, age tracking, round-robin pointer and output stage
   always_comb begin
      hold_v_d  = w_xfer | (hold_v_q & ~w_grant);
      age_d     = 1'b0;
      tie_d     = 1'b0;
      rr_ptr_d  = rr_ptr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_src_d  = wr_src_q;

      if (&hold_v_d) begin
         if (&w_xfer) begin
            tie_d = 1'b1;
         end else if (w_xfer[0]) begin
            // Fresh ALU entry is younger than the retained MEM entry
            age_d = 1'b1;
         end else if (w_xfer[1]) begin
            age_d = 1'b0;
         end else begin
            age_d = age_q;
            tie_d = tie_q;
         end
      end

      if (w_any) begin
         wr_en_d   = !(ZRO && (hold_addr_q[w_sel] == '0));
         wr_addr_d = hold_addr_q[w_sel];
         wr_data_d = hold_data_q[w_sel];
         wr_src_d  = w_sel;
         if ((&hold_v_q) && tie_q) begin
            rr_ptr_d = ~rr_ptr_q;
         end
      end

      if (flush_i) begin
         hold_v_d = 2'b00;
         age_d    = 1'b0;
         tie_d    = 1'b0;
         rr_ptr_d = rr_ptr_q;
         wr_en_d  = 1'b0;
         wr_addr_d = wr_addr_q;
         wr_data_d = wr_data_q;
         wr_src_d  = wr_src_q;
      end
   end

   // State registers; data is captured into a holding slot only on a transfer
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_v_q       <= 2'b00;
         hold_addr_q[0] <= '0;
         hold_addr_q[1] <= '0;
         hold_data_q[0] <= '0;
         hold_data_q[1] <= '0;
         age_q          <= 1'b0;
         tie_q          <= 1'b0;
         rr_ptr_q       <= RR_RST;
         wr_en_q        <= 1'b0;
         wr_addr_q      <= '0;
         wr_data_q      <= '0;
         wr_src_q       <= 1'b0;
      end else begin
         hold_v_q  <= hold_v_d;
         age_q     <= age_d;
         tie_q     <= tie_d;
         rr_ptr_q  <= rr_ptr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_src_q  <= wr_src_d;
         for (int i = 0; i < 2; i++) begin
            if (w_xfer[i]) begin
               hold_addr_q[i] <= w_in_addr[i];
               hold_data_q[i] <= w_in_data[i];
            end
         end
      end
   end

   // Pending mask: every held destination plus the one currently on the write port
   always_comb begin
      w_pend = '0;
      for (int i = 0; i < 2; i++) begin
         if (hold_v_q[i]) begin
            w_pend[hold_addr_q[i]] = 1'b1;
         end
      end
      if (wr_en_q) begin
         w_pend[wr_addr_q] = 1'b1;
      end
      if (ZRO) begin
         w_pend[0] = 1'b0;
      end
   end

   assign wr_en_o     = wr_en_q;
   assign wr_addr_o   = wr_addr_q;
   assign wr_data_o   = wr_data_q;
   assign wr_src_o    = wr_src_q;
   assign pend_mask_o = w_pend;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_regfile_wr_arbiter                                      |
// | Description : Self-checking bench: vector table of single-edge offers,   |
// |               write scoreboard, and sequences for ordering, streaming,   |
// |               zero-register, flush and asynchronous reset behaviour.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_regfile_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n, flush;
   logic        alu_valid, mem_valid;
   logic [4:0]  alu_addr, mem_addr;
   logic [31:0] alu_data, mem_data;
   logic        alu_ready, mem_ready, wr_en, wr_src;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data, pend_mask;
   logic        z_alu_ready, z_mem_ready, z_wr_en, z_wr_src;
   logic [4:0]  z_wr_addr;
   logic [31:0] z_wr_data, z_pend_mask;

   always #5 clk = ~clk;

   regfile_wr_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG_RO(1), .TIE_FIRST(0)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_addr_i(alu_addr), .alu_data_i(alu_data),
      .mem_valid_i(mem_valid), .mem_ready_o(mem_ready), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
      .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_src_o(wr_src),
      .pend_mask_o(pend_mask));

   regfile_wr_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG_RO(0), .TIE_FIRST(0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .alu_valid_i(alu_valid), .alu_ready_o(z_alu_ready), .alu_addr_i(alu_addr), .alu_data_i(alu_data),
      .mem_valid_i(mem_valid), .mem_ready_o(z_mem_ready), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
      .wr_en_o(z_wr_en), .wr_addr_o(z_wr_addr), .wr_data_o(z_wr_data), .wr_src_o(z_wr_src),
      .pend_mask_o(z_pend_mask));

   typedef struct {
      logic        av; logic [4:0] aa; logic [31:0] ad;
      logic        mv; logic [4:0] ma; logic [31:0] md;
      logic        first;
   } vec_t;

   typedef struct {
      logic src; logic [4:0] addr; logic [31:0] data;
   } wr_t;

   vec_t        vecs [8];
   wr_t         sb [$];
   logic [31:0] rf [32];
   int          n_cmp = 0, n_fail = 0, cyc = 0;
   int          pulses = 0, first_p = -1, last_p = -1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected write for the ZERO_REG_RO=1 instance; register 0 is never issued
   task automatic push(input logic src, input logic [4:0] addr, input logic [31:0] data);
      wr_t e;
      e.src = src; e.addr = addr; e.data = data;
      if (addr != 5'd0) sb.push_back(e);
   endtask

   task automatic step();
      wr_t e;
      @(posedge clk); #1;
      cyc++;
      if (wr_en) begin
         rf[wr_addr] = wr_data;
         pulses++;
         if (first_p < 0) first_p = cyc;
         last_p = cyc;
         if (sb.size() == 0) begin
            chk("unexpected_write", {26'd0, wr_src, wr_addr, wr_data}, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("write", {26'd0, wr_src, wr_addr, wr_data}, {26'd0, e.src, e.addr, e.data});
         end
      end
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; mem_valid = 1'b0; flush = 1'b0;
   endtask

   initial begin
      logic [31:0] m;
      int na, nm;
      logic acc_a, acc_m;

      // Table starts from rr pointer = ALU; every tie flips it
      vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,  1'b0};
      vecs[1] = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22, 1'b0};
      vecs[2] = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd4,  32'h44, 1'b1};
      vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h55, 1'b1};
      vecs[4] = '{1'b1, 5'd0,  32'h5,        1'b0, 5'd0,  32'h0,  1'b0};
      vecs[5] = '{1'b1, 5'd1,  32'h101,      1'b1, 5'd2,  32'h202, 1'b0};
      vecs[6] = '{1'b1, 5'd0,  32'h7,        1'b1, 5'd6,  32'h66, 1'b1};
      vecs[7] = '{1'b1, 5'd8,  32'h88,       1'b1, 5'd0,  32'h99, 1'b0};
      for (int r = 0; r < 32; r++) rf[r] = 32'h0;

      rst_n = 1'b0; idle_inputs();
      alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
      #12;
      chk("rst_wr_en", wr_en, 1'b0);
      chk("rst_wr_addr", wr_addr, 5'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_wr_src", wr_src, 1'b0);
      chk("rst_pend", pend_mask, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_ready", {alu_ready, mem_ready}, 2'b11);

      // Vector table: one offer per record from an idle arbiter
      for (int v = 0; v < 8; v++) begin
         chk($sformatf("v%0d_ready", v), {alu_ready, mem_ready}, 2'b11);
         alu_valid = vecs[v].av; alu_addr = vecs[v].aa; alu_data = vecs[v].ad;
         mem_valid = vecs[v].mv; mem_addr = vecs[v].ma; mem_data = vecs[v].md;
         m = 32'd0;
         if (vecs[v].av && vecs[v].aa != 5'd0) m[vecs[v].aa] = 1'b1;
         if (vecs[v].mv && vecs[v].ma != 5'd0) m[vecs[v].ma] = 1'b1;
         if (vecs[v].av && vecs[v].mv) begin
            if (vecs[v].first == 1'b0) begin
               push(1'b0, vecs[v].aa, vecs[v].ad); push(1'b1, vecs[v].ma, vecs[v].md);
            end else begin
               push(1'b1, vecs[v].ma, vecs[v].md); push(1'b0, vecs[v].aa, vecs[v].ad);
            end
         end else if (vecs[v].av) begin
            push(1'b0, vecs[v].aa, vecs[v].ad);
         end else begin
            push(1'b1, vecs[v].ma, vecs[v].md);
         end
         step();
         idle_inputs();
         chk($sformatf("v%0d_pend_E0", v), pend_mask, m);
         repeat (3) step();
         chk($sformatf("v%0d_pend_idle", v), pend_mask, 32'd0);
         chk($sformatf("v%0d_drained", v), sb.size(), 0);
      end

      // Streaming: pointer now at MEM, so strict M,A,M,A... order, one write per cycle
      for (int k = 0; k < 5; k++) begin
         push(1'b1, 5'(20 + k), 32'hB000 + k);
         push(1'b0, 5'(10 + k), 32'hA000 + k);
      end
      pulses = 0; first_p = -1; last_p = -1;
      na = 0; nm = 0;
      for (int c = 0; c < 40 && (na < 5 || nm < 5); c++) begin
         alu_valid = (na < 5); alu_addr = 5'(10 + na); alu_data = 32'hA000 + na;
         mem_valid = (nm < 5); mem_addr = 5'(20 + nm); mem_data = 32'hB000 + nm;
         acc_a = alu_valid && alu_ready;
         acc_m = mem_valid && mem_ready;
         step();
         if (acc_a) na++;
         if (acc_m) nm++;
      end
      idle_inputs();
      chk("stream_accepts", {na[7:0], nm[7:0]}, {8'd5, 8'd5});
      repeat (4) step();
      chk("stream_pulses", pulses, 10);
      chk("stream_no_gap", last_p - first_p + 1, 10);
      chk("stream_drained", sb.size(), 0);

      // Same-register ordering: MEM r7 held behind ALU, then ALU r7 arrives younger
      alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'h1;
      mem_valid = 1'b1; mem_addr = 5'd7;  mem_data = 32'h77;
      push(1'b0, 5'd12, 32'h1);
      step();
      chk("ord_ready", {alu_ready, mem_ready}, 2'b10);
      alu_addr = 5'd7; alu_data = 32'hAA; mem_valid = 1'b0;
      push(1'b1, 5'd7, 32'h77); push(1'b0, 5'd7, 32'hAA);
      step();
      idle_inputs();
      repeat (4) step();
      chk("ord_rf7", rf[7], 32'hAA);
      chk("ord_drained", sb.size(), 0);

      // Register 0: suppressed on the read-only instance, issued on the other
      alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h5;
      step();
      idle_inputs();
      chk("z_ready", alu_ready, 1'b1);
      chk("z_pend_ro", pend_mask, 32'd0);
      chk("z_pend_rw", z_pend_mask, 32'd1);
      step();
      chk("z_wr_en_ro", wr_en, 1'b0);
      chk("z_wr_rw", {z_wr_en, z_wr_addr, z_wr_data}, {1'b1, 5'd0, 32'h5});
      repeat (2) step();

      // Flush with both holds full; an offer during the flush is dropped
      alu_valid = 1'b1; alu_addr = 5'd13; alu_data = 32'hD;
      mem_valid = 1'b1; mem_addr = 5'd14; mem_data = 32'hE;
      push(1'b1, 5'd14, 32'hE);
      step();
      alu_valid = 1'b0; mem_addr = 5'd16; mem_data = 32'h16;
      step();
      mem_valid = 1'b0;
      chk("fl_pend_full", pend_mask, 32'h0001_6000);
      flush = 1'b1; alu_valid = 1'b1; alu_addr = 5'd17; alu_data = 32'h17;
      step();
      idle_inputs();
      chk("fl_wr_en", wr_en, 1'b0);
      chk("fl_pend", pend_mask, 32'd0);
      chk("fl_ready", {alu_ready, mem_ready}, 2'b11);
      repeat (3) step();
      chk("fl_drained", sb.size(), 0);

      // Tie to move the pointer to MEM, then async reset mid-write
      alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'h20;
      mem_valid = 1'b1; mem_addr = 5'd21; mem_data = 32'h21;
      push(1'b0, 5'd20, 32'h20); push(1'b1, 5'd21, 32'h21);
      step();
      idle_inputs();
      repeat (3) step();
      alu_valid = 1'b1; alu_addr = 5'd18; alu_data = 32'h99;
      push(1'b0, 5'd18, 32'h99);
      step();
      idle_inputs();
      step();
      chk("rs_wr_before", wr_en, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      chk("rs_wr_en", wr_en, 1'b0);
      chk("rs_wr_bus", {wr_addr, wr_data}, 37'd0);
      chk("rs_pend", pend_mask, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rs_ready", {alu_ready, mem_ready}, 2'b11);
      // Pointer back at TIE_FIRST (ALU) after reset
      alu_valid = 1'b1; alu_addr = 5'd22; alu_data = 32'h22;
      mem_valid = 1'b1; mem_addr = 5'd23; mem_data = 32'h23;
      push(1'b0, 5'd22, 32'h22); push(1'b1, 5'd23, 32'h23);
      step();
      idle_inputs();
      repeat (3) step();
      chk("rs_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
